// File: rtl/axi_read_arbiter.sv
// Two-master round-robin arbiter sharing one slave AXI read port (AR and R channels).
// The grant is locked from AR issue until the RLAST handshake; R is routed by the registered grant.
module axi_read_arbiter #(
  parameter int ID_W   = 4,
  parameter int IDS_W  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  // master 0
  input  logic [ID_W-1:0]   ARID_M0,
  input  logic [ADDR_W-1:0] ARADDR_M0,
  input  logic [3:0]        ARLEN_M0,
  input  logic [2:0]        ARSIZE_M0,
  input  logic [1:0]        ARBURST_M0,
  input  logic              ARVALID_M0,
  output logic              ARREADY_M0,
  output logic [ID_W-1:0]   RID_M0,
  output logic [DATA_W-1:0] RDATA_M0,
  output logic [1:0]        RRESP_M0,
  output logic              RLAST_M0,
  output logic              RVALID_M0,
  input  logic              RREADY_M0,
  // master 1
  input  logic [ID_W-1:0]   ARID_M1,
  input  logic [ADDR_W-1:0] ARADDR_M1,
  input  logic [3:0]        ARLEN_M1,
  input  logic [2:0]        ARSIZE_M1,
  input  logic [1:0]        ARBURST_M1,
  input  logic              ARVALID_M1,
  output logic              ARREADY_M1,
  output logic [ID_W-1:0]   RID_M1,
  output logic [DATA_W-1:0] RDATA_M1,
  output logic [1:0]        RRESP_M1,
  output logic              RLAST_M1,
  output logic              RVALID_M1,
  input  logic              RREADY_M1,
  // slave
  output logic [IDS_W-1:0]  ARID_S,
  output logic [ADDR_W-1:0] ARADDR_S,
  output logic [3:0]        ARLEN_S,
  output logic [2:0]        ARSIZE_S,
  output logic [1:0]        ARBURST_S,
  output logic              ARVALID_S,
  input  logic              ARREADY_S,
  input  logic [IDS_W-1:0]  RID_S,
  input  logic [DATA_W-1:0] RDATA_S,
  input  logic [1:0]        RRESP_S,
  input  logic              RLAST_S,
  input  logic              RVALID_S,
  output logic              RREADY_S
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t r_state, w_state_nxt;
  logic   r_grant, w_grant_nxt;
  logic   r_last,  w_last_nxt;

  logic   w_req, w_win, w_sel, w_fwd, w_dat, w_rdone;
  logic   w_r0, w_r1;
  logic   w_unused_rid_hi;

  // Upper slave RID bits only carry the master index, which the registered grant already knows.
  assign w_unused_rid_hi = ^RID_S[IDS_W-1:ID_W];

  assign w_req = ARVALID_M0 | ARVALID_M1;
  assign w_win = (ARVALID_M0 & ARVALID_M1) ? ~r_last : ARVALID_M1;
  assign w_sel = (r_state == IDLE) ? w_win : r_grant;
  assign w_fwd = ((r_state == IDLE) & w_req) | (r_state == ADDR);
  assign w_dat = (r_state == DATA);
  assign w_r0  = w_dat & ~r_grant;
  assign w_r1  = w_dat &  r_grant;

  // AR forwarding
  always_comb begin
    ARID_S     = '0;
    ARADDR_S   = '0;
    ARLEN_S    = '0;
    ARSIZE_S   = '0;
    ARBURST_S  = '0;
    ARVALID_S  = 1'b0;
    ARREADY_M0 = 1'b0;
    ARREADY_M1 = 1'b0;
    if (w_fwd) begin
      ARVALID_S = 1'b1;
      if (w_sel) begin
        ARID_S     = {(IDS_W-ID_W)'(1'b1), ARID_M1};
        ARADDR_S   = ARADDR_M1;
        ARLEN_S    = ARLEN_M1;
        ARSIZE_S   = ARSIZE_M1;
        ARBURST_S  = ARBURST_M1;
        ARREADY_M1 = ARREADY_S;
      end else begin
        ARID_S     = {(IDS_W-ID_W)'(1'b0), ARID_M0};
        ARADDR_S   = ARADDR_M0;
        ARLEN_S    = ARLEN_M0;
        ARSIZE_S   = ARSIZE_M0;
        ARBURST_S  = ARBURST_M0;
        ARREADY_M0 = ARREADY_S;
      end
    end
  end

  // R routing; RVALID_S outside DATA is held off by RREADY_S=0
  assign RVALID_M0 = w_r0 & RVALID_S;
  assign RID_M0    = w_r0 ? RID_S[ID_W-1:0] : '0;
  assign RDATA_M0  = w_r0 ? RDATA_S : '0;
  assign RRESP_M0  = w_r0 ? RRESP_S : '0;
  assign RLAST_M0  = w_r0 & RLAST_S;

  assign RVALID_M1 = w_r1 & RVALID_S;
  assign RID_M1    = w_r1 ? RID_S[ID_W-1:0] : '0;
  assign RDATA_M1  = w_r1 ? RDATA_S : '0;
  assign RRESP_M1  = w_r1 ? RRESP_S : '0;
  assign RLAST_M1  = w_r1 & RLAST_S;

  assign RREADY_S  = (w_r0 & RREADY_M0) | (w_r1 & RREADY_M1);
  assign w_rdone   = RVALID_S & RREADY_S & RLAST_S;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_grant_nxt = w_win;
          w_state_nxt = ARREADY_S ? DATA : ADDR;
        end
      end
      ADDR: begin
        if (ARREADY_S) w_state_nxt = DATA;
      end
      DATA: begin
        if (w_rdone) begin
          w_state_nxt = IDLE;
          w_last_nxt  = r_grant;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= IDLE;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: arbitration order, AR backpressure, burst stall, RID routing, reset.
module tb_axi_read_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [3:0]  ARID_M0, ARID_M1;
  logic [31:0] ARADDR_M0, ARADDR_M1;
  logic [3:0]  ARLEN_M0, ARLEN_M1;
  logic [2:0]  ARSIZE_M0, ARSIZE_M1;
  logic [1:0]  ARBURST_M0, ARBURST_M1;
  logic        ARVALID_M0, ARVALID_M1;
  logic        ARREADY_M0, ARREADY_M1;
  logic [3:0]  RID_M0, RID_M1;
  logic [31:0] RDATA_M0, RDATA_M1;
  logic [1:0]  RRESP_M0, RRESP_M1;
  logic        RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1;
  logic        RREADY_M0, RREADY_M1;
  logic [7:0]  ARID_S;
  logic [31:0] ARADDR_S;
  logic [3:0]  ARLEN_S;
  logic [2:0]  ARSIZE_S;
  logic [1:0]  ARBURST_S;
  logic        ARVALID_S, ARREADY_S;
  logic [7:0]  RID_S;
  logic [31:0] RDATA_S;
  logic [1:0]  RRESP_S;
  logic        RLAST_S, RVALID_S, RREADY_S;

  int n_tests = 0;
  int n_fail  = 0;

  axi_read_arbiter #(.ID_W(4), .IDS_W(8), .ADDR_W(32), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0), .ARSIZE_M0(ARSIZE_M0),
    .ARBURST_M0(ARBURST_M0), .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
    .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0),
    .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
    .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1), .ARSIZE_M1(ARSIZE_M1),
    .ARBURST_M1(ARBURST_M1), .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
    .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1),
    .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    ARID_M0 = '0; ARADDR_M0 = '0; ARLEN_M0 = '0; ARSIZE_M0 = '0; ARBURST_M0 = '0; ARVALID_M0 = 0;
    ARID_M1 = '0; ARADDR_M1 = '0; ARLEN_M1 = '0; ARSIZE_M1 = '0; ARBURST_M1 = '0; ARVALID_M1 = 0;
    RREADY_M0 = 0; RREADY_M1 = 0; ARREADY_S = 0;
    RID_S = '0; RDATA_S = '0; RRESP_S = '0; RLAST_S = 0; RVALID_S = 0;
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    clear_inputs();
    tick();
    ARESETn = 1'b1;
  endtask

  initial begin
    ARESETn = 1'b0;
    clear_inputs();
    settle();
    chk("rst_arvalid_s", ARVALID_S, 0);
    chk("rst_arready", {ARREADY_M0, ARREADY_M1}, 0);
    chk("rst_rready_s", RREADY_S, 0);
    chk("rst_rvalid", {RVALID_M0, RVALID_M1}, 0);
    chk("rst_arid_s", ARID_S, 0);
    chk("rst_araddr_s", ARADDR_S, 0);
    tick();
    ARESETn = 1'b1;

    // single M0 read
    ARVALID_M0 = 1; ARADDR_M0 = 32'h0000_0100; ARID_M0 = 4'h0; ARSIZE_M0 = 3'd2; ARBURST_M0 = 2'd1;
    ARREADY_S = 1;
    settle();
    chk("t1_arvalid_s", ARVALID_S, 1);
    chk("t1_arid_s", ARID_S, 8'h00);
    chk("t1_araddr_s", ARADDR_S, 32'h0000_0100);
    chk("t1_arsize_burst", {ARSIZE_S, ARBURST_S}, {3'd2, 2'd1});
    chk("t1_arready", {ARREADY_M0, ARREADY_M1}, 2'b10);
    tick();
    ARVALID_M0 = 0; ARREADY_S = 0;
    RVALID_S = 1; RLAST_S = 1; RDATA_S = 32'hDEAD_BEEF; RRESP_S = 2'd0; RREADY_M0 = 1;
    settle();
    chk("t1_rvalid_m0", RVALID_M0, 1);
    chk("t1_rdata_m0", RDATA_M0, 32'hDEAD_BEEF);
    chk("t1_rlast_m0", RLAST_M0, 1);
    chk("t1_rvalid_m1", RVALID_M1, 0);
    chk("t1_rready_s", RREADY_S, 1);
    chk("t1_arvalid_s_data", ARVALID_S, 0);
    tick();
    // back in IDLE: a stray slave beat must be held off
    settle();
    chk("t1_idle_rvalid", {RVALID_M0, RVALID_M1}, 0);
    chk("t1_idle_rready_s", RREADY_S, 0);
    RVALID_S = 0; RLAST_S = 0; RDATA_S = '0; RREADY_M0 = 0;

    // simultaneous requests after reset; fairness and RID routing
    do_reset();
    ARVALID_M0 = 1; ARADDR_M0 = 32'h0000_0200; ARID_M0 = 4'h0;
    ARVALID_M1 = 1; ARADDR_M1 = 32'h0000_0300; ARID_M1 = 4'h1;
    ARREADY_S = 1;
    settle();
    chk("t2_c1_arid_s", ARID_S, 8'h00);
    chk("t2_c1_araddr_s", ARADDR_S, 32'h0000_0200);
    chk("t2_c1_arready", {ARREADY_M0, ARREADY_M1}, 2'b10);
    tick();
    ARVALID_M0 = 0;
    RVALID_S = 1; RLAST_S = 1; RDATA_S = 32'h0000_00AA; RREADY_M0 = 1;
    settle();
    chk("t2_data_arvalid_s", ARVALID_S, 0);
    chk("t2_data_arready_m1", ARREADY_M1, 0);
    chk("t2_data_rvalid_m0", RVALID_M0, 1);
    tick();
    RVALID_S = 0; RLAST_S = 0; RREADY_M0 = 0;
    ARVALID_M0 = 1;
    settle();
    chk("t2_c2_arid_s", ARID_S, 8'h11);
    chk("t2_c2_araddr_s", ARADDR_S, 32'h0000_0300);
    chk("t2_c2_arready", {ARREADY_M0, ARREADY_M1}, 2'b01);
    tick();
    ARVALID_M1 = 0;
    RVALID_S = 1; RLAST_S = 1; RID_S = 8'h15; RDATA_S = 32'h0000_1234; RRESP_S = 2'd2; RREADY_M1 = 1;
    settle();
    chk("t2_rid_m1", RID_M1, 4'h5);
    chk("t2_rvalid_m1", RVALID_M1, 1);
    chk("t2_rdata_m1", RDATA_M1, 32'h0000_1234);
    chk("t2_rresp_m1", RRESP_M1, 2'd2);
    chk("t2_rvalid_m0", RVALID_M0, 0);
    chk("t2_rdata_m0", RDATA_M0, 0);
    chk("t2_rready_s", RREADY_S, 1);
    tick();
    RVALID_S = 0; RLAST_S = 0; RID_S = '0; RRESP_S = '0; RREADY_M1 = 0;
    ARVALID_M1 = 1;
    settle();
    chk("t2_c3_arid_s", ARID_S, 8'h00);
    chk("t2_c3_araddr_s", ARADDR_S, 32'h0000_0200);
    chk("t2_c3_arready", {ARREADY_M0, ARREADY_M1}, 2'b10);
    tick();
    ARVALID_M0 = 0; ARVALID_M1 = 0; ARREADY_S = 0;
    RVALID_S = 1; RLAST_S = 1; RREADY_M0 = 1;
    tick();
    RVALID_S = 0; RLAST_S = 0; RREADY_M0 = 0;

    // slave AR backpressure on M1; M0 joins in cycle 2
    ARVALID_M1 = 1; ARADDR_M1 = 32'h0000_0300; ARREADY_S = 0;
    settle();
    chk("t3_c1_araddr_s", ARADDR_S, 32'h0000_0300);
    chk("t3_c1_arready", {ARREADY_M0, ARREADY_M1}, 2'b00);
    tick();
    ARVALID_M0 = 1;
    settle();
    chk("t3_c2_araddr_s", ARADDR_S, 32'h0000_0300);
    chk("t3_c2_arready", {ARREADY_M0, ARREADY_M1}, 2'b00);
    tick();
    settle();
    chk("t3_c3_araddr_s", ARADDR_S, 32'h0000_0300);
    chk("t3_c3_arid_s", ARID_S, 8'h11);
    tick();
    ARREADY_S = 1;
    settle();
    chk("t3_c4_araddr_s", ARADDR_S, 32'h0000_0300);
    chk("t3_c4_arready", {ARREADY_M0, ARREADY_M1}, 2'b01);
    tick();
    ARVALID_M1 = 0;
    RVALID_S = 1; RLAST_S = 1; RREADY_M1 = 1;
    settle();
    chk("t3_data_arready_m0", ARREADY_M0, 0);
    chk("t3_data_arvalid_s", ARVALID_S, 0);
    chk("t3_data_rvalid_m1", RVALID_M1, 1);
    tick();
    RVALID_S = 0; RLAST_S = 0; RREADY_M1 = 0;

    // M0 4-beat burst with an R stall on the second cycle
    ARLEN_M0 = 4'd3;
    settle();
    chk("t4_arready_m0", ARREADY_M0, 1);
    chk("t4_araddr_s", ARADDR_S, 32'h0000_0200);
    chk("t4_arlen_s", ARLEN_S, 4'd3);
    tick();
    ARVALID_M0 = 0; ARREADY_S = 0;
    RVALID_S = 1;
    // rready 1,0,1,1,1 : beats 1, (stall on 2), 2, 3, 4
    RREADY_M0 = 1; RLAST_S = 0; RDATA_S = 32'h0000_0B01;
    settle();
    chk("t4_b1_rready_s", RREADY_S, 1);
    chk("t4_b1_rlast_m0", RLAST_M0, 0);
    chk("t4_b1_rdata_m0", RDATA_M0, 32'h0000_0B01);
    tick();
    RREADY_M0 = 0; RDATA_S = 32'h0000_0B02;
    settle();
    chk("t4_stall_rready_s", RREADY_S, 0);
    chk("t4_stall_rvalid_m0", RVALID_M0, 1);
    tick();
    RREADY_M0 = 1;
    settle();
    chk("t4_b2_rready_s", RREADY_S, 1);
    chk("t4_b2_rdata_m0", RDATA_M0, 32'h0000_0B02);
    chk("t4_b2_rlast_m0", RLAST_M0, 0);
    tick();
    RDATA_S = 32'h0000_0B03;
    settle();
    chk("t4_b3_rlast_m0", RLAST_M0, 0);
    chk("t4_b3_rvalid_m0", RVALID_M0, 1);
    tick();
    RDATA_S = 32'h0000_0B04; RLAST_S = 1;
    settle();
    chk("t4_b4_rvalid_m0", RVALID_M0, 1);
    chk("t4_b4_rlast_m0", RLAST_M0, 1);
    chk("t4_b4_rready_s", RREADY_S, 1);
    tick();
    settle();
    chk("t4_after_rvalid_m0", RVALID_M0, 0);
    chk("t4_after_rready_s", RREADY_S, 0);
    RVALID_S = 0; RLAST_S = 0; RREADY_M0 = 0; ARLEN_M0 = '0;

    // reset in the middle of a 4-beat M1 burst
    ARVALID_M1 = 1; ARADDR_M1 = 32'h0000_0400; ARLEN_M1 = 4'd3; ARREADY_S = 1;
    tick();
    ARVALID_M1 = 0; ARREADY_S = 0;
    RVALID_S = 1; RREADY_M1 = 1;
    tick();
    tick();
    settle();
    chk("t5_pre_rvalid_m1", RVALID_M1, 1);
    ARESETn = 1'b0;
    settle();
    chk("t5_rst_rready_s", RREADY_S, 0);
    chk("t5_rst_rvalid_m1", RVALID_M1, 0);
    chk("t5_rst_arvalid_s", ARVALID_S, 0);
    clear_inputs();
    tick();
    ARESETn = 1'b1;
    ARVALID_M0 = 1; ARADDR_M0 = 32'h0000_0500;
    ARVALID_M1 = 1; ARADDR_M1 = 32'h0000_0600; ARID_M1 = 4'h1;
    ARREADY_S = 1;
    settle();
    chk("t5_post_arid_s", ARID_S, 8'h00);
    chk("t5_post_araddr_s", ARADDR_S, 32'h0000_0500);
    chk("t5_post_arready", {ARREADY_M0, ARREADY_M1}, 2'b10);
    tick();
    clear_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Two-master, one-slave AXI read-channel arbiter (AR and R channels only) inside the bus interconnect.
- Shares one slave read port between Master0 (instruction fetch) and Master1 (load path).
- Round-robin grant; the grant is held from AR acceptance through the RLAST beat.
- Slave-side ID is prefixed with the granted master index; read data is routed back to the granted master by the registered grant.

Parameters:
- ID_W, 4, master-side AXI ID width
- IDS_W, 8, slave-side ID width ({4'(master index), master ID}); must be ≥ ID_W+1
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  reset
- ARID_M0/ARADDR_M0/ARLEN_M0/ARSIZE_M0/ARBURST_M0  in  ID_W/ADDR_W/4/3/2  M0 AR payload
- ARVALID_M0 in 1; ARREADY_M0 out 1  M0 AR handshake
- RID_M0/RDATA_M0/RRESP_M0/RLAST_M0/RVALID_M0  out  ID_W/DATA_W/2/1/1  M0 R channel; RREADY_M0 in 1
- ARID_M1 … RREADY_M1  same set as M0, for Master1
- ARID_S  out  IDS_W  slave AR ID; ARADDR_S/ARLEN_S/ARSIZE_S/ARBURST_S out; ARVALID_S out 1; ARREADY_S in 1
- RID_S in IDS_W; RDATA_S/RRESP_S/RLAST_S/RVALID_S in; RREADY_S out 1

Behaviour:
- Interface (already decided): single clock ACLK; reset ARESETn is asynchronous and active-low.
- Registers:
  - state ∈ {IDLE, ADDR, DATA}
  - grant (1 bit, current owner)
  - last (1 bit, last-served master)
- Reset values: state=IDLE, grant=0, last=1 (so M0 wins the first tie).
- Outputs are combinational from state, grant and inputs. With no ARVALID_Mx during or after reset, every VALID/READY output is 0 and every payload output is 0.
- IDLE:
  - Select winner: only one ARVALID → that master; both → the master ≠ last; none → stay, all outputs 0.
  - Winner's AR is forwarded the same cycle: ARVALID_S=1, ARID_S={pad(idx),ARID_Mw}, other fields passed through. ARREADY_Mw=ARREADY_S; loser's ARREADY=0.
  - ARREADY_S=1 → DATA, grant<=w. Else → ADDR, grant<=w (grant locked, since an asserted VALID must not be abandoned).
- ADDR:
  - Forward AR of master[grant]; ARREADY_M[grant]=ARREADY_S; other master's ARREADY=0.
  - ARREADY_S=1 → DATA. A new ARVALID from the other master is ignored.
- DATA:
  - ARVALID_S=0; both ARREADY_Mx=0.
  - RVALID_M[grant]=RVALID_S; RREADY_S=RREADY_M[grant]; RID_M[grant]=RID_S[ID_W-1:0]; RDATA, RRESP and RLAST passed through.
  - Non-granted master: RVALID=0; its RDATA/RID/RRESP/RLAST=0.
  - RVALID_S & RREADY_S & RLAST_S → IDLE, last<=grant. The next arbitration can occur in the following cycle; no same-cycle AR overlap with the final beat.
  - Beats without RLAST stay in DATA; multi-beat bursts (ARLEN up to 15) pass through unmodified.
- Outside DATA: RREADY_S=0 and both RVALID_Mx=0. Stray RVALID_S is held off, never dropped.
- ARESETn assertion mid-transaction: immediate return to reset values, all valids deasserted asynchronously; the in-flight burst is abandoned.
- Fairness: with both masters continuously requesting, grants strictly alternate, M0 first after reset.
- Throughput: one transaction in flight. Minimum 2 cycles per single-beat read (AR in IDLE, R in DATA).

Test Plan:
- Single M0 read: ARVALID_M0=1, ARADDR_M0=0x0000_0100, ARID_M0=4'h0, ARREADY_S=1 in the same cycle → ARVALID_S=1 and ARID_S=8'h00 that cycle. Next cycle RVALID_S=1, RLAST_S=1, RDATA_S=0xDEAD_BEEF → RVALID_M0=1, RDATA_M0=0xDEAD_BEEF, RVALID_M1=0; state back to IDLE.
- Simultaneous requests after reset: both ARVALID=1 → M0 granted (ARID_S=8'h00, ARADDR_S=ARADDR_M0), ARREADY_M1=0. After M0's RLAST, M1 is granted with ARID_S=8'h11 for ARID_M1=4'h1. Third contention goes to M0.
- Slave AR backpressure: M1 requests, ARREADY_S=0 for 3 cycles, M0 raises ARVALID on cycle 2 → ARADDR_S stays M1's address all 4 cycles; M0 receives no ARREADY until M1's read completes.
- Burst with R stall: M0 issues ARLEN=4'd3; slave sends 4 beats while RREADY_M0 toggles 1,0,1,1,1 → RREADY_S mirrors RREADY_M0; RLAST_M0 is set only on beat 4; the arbiter leaves DATA only after that handshake.
- RID routing: during M1's grant the slave returns RID_S=8'h15 → RID_M1=4'h5, RVALID_M0 stays 0.
- Reset mid-burst: ARESETn=0 after beat 2 of a 4-beat M1 read → RREADY_S, RVALID_M1 and ARVALID_S go 0 immediately. After release, simultaneous requests grant M0 first.
